// File: rtl/shift_engine_pkg.sv
// shift_engine_pkg: state encoding and clog2 helper shared by the shift engine files
package shift_engine_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_SHIFT = ST_SHIFT, S_DONE = ST_DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/shift_engine_slice.sv
// shift_engine_slice: one register bit, choosing parallel load or shift-in, with clock enable
module shift_engine_slice #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic ld,
  input  logic ld_bit,
  input  logic sh_bit,
  output logic q
);
  logic q_d, q_q;
  always_comb q_d = ld ? ld_bit : sh_bit;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) q_q <= RST_BIT;
    else if (en) q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/shift_engine_param.sv
// shift_engine_param: parametrised full-duplex MSB-first shift engine with start/done handshake
// Optional parity output enabled by defining SHIFT_ENGINE_PARITY_EN.
module shift_engine_param
  import shift_engine_pkg::*;
#(
  parameter int              WIDTH       = 14,
  parameter int              SHIFT_COUNT = WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
`ifdef SHIFT_ENGINE_PARITY_EN
  ,
  output logic             parity
`endif
);
  localparam int CW = clog2(WIDTH + 1);
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] sh_in;
  logic ld, sh, last, en;
  assign sh_in = {q[WIDTH-2:0], serial_in};
  always_comb begin
    ld      = (state_q != S_SHIFT) && start;
    sh      = state_q == S_SHIFT;
    last    = sh && (count_q == CW'(SHIFT_COUNT - 1));
    en      = enable && (ld || sh);
    state_d = ld ? S_SHIFT : last ? S_DONE : sh ? S_SHIFT : S_IDLE;
    count_d = (ld || last) ? '0 : sh ? count_q + CW'(1) : count_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else if (enable) begin
      state_q <= state_d;
      count_q <= count_d;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    shift_engine_slice #(.RST_BIT(RESET_VALUE[i])) u_slice (
      .clk   (clk),
      .resetn(resetn),
      .en    (en),
      .ld    (ld),
      .ld_bit(load_data[i]),
      .sh_bit(sh_in[i]),
      .q     (q[i])
    );
  end
  assign serial_out = q[WIDTH-1];
  assign busy       = state_q == S_SHIFT;
  assign done       = state_q == S_DONE;
`ifdef SHIFT_ENGINE_PARITY_EN
  // sh_in is exactly the word that enters DONE on the last shift edge
  logic parity_q, parity_d;
  always_comb parity_d = last ? ^sh_in : parity_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) parity_q <= 1'b0;
    else if (enable) parity_q <= parity_d;
  assign parity = parity_q;
`endif
endmodule

// File: tb/tb_shift_engine_param.sv
// tb_shift_engine_param: scoreboard bench for shift_engine_param (14-bit full and 4-shift builds)
module tb_shift_engine_param;
  logic clk = 0, resetn = 0, enable = 1, start = 0, start4 = 0, serial_in = 0;
  logic [13:0] load_data = '0, q, q4, e_m, e_4;
  logic serial_out, serial_out4, busy, done, busy4, done4;
`ifdef SHIFT_ENGINE_PARITY_EN
  logic parity, parity4;
`endif
  int n_vec = 0, n_bad = 0, busy_len = 0;
  logic        exp_bits[$];
  logic [13:0] exp_q[$], exp4[$];

  always #5 clk = ~clk;

  shift_engine_param #(.WIDTH(14)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start), .load_data(load_data),
    .serial_in(serial_in), .serial_out(serial_out), .q(q), .busy(busy), .done(done)
`ifdef SHIFT_ENGINE_PARITY_EN
    , .parity(parity)
`endif
  );

  shift_engine_param #(.WIDTH(14), .SHIFT_COUNT(4)) dut4 (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start4), .load_data(load_data),
    .serial_in(serial_in), .serial_out(serial_out4), .q(q4), .busy(busy4), .done(done4)
`ifdef SHIFT_ENGINE_PARITY_EN
    , .parity(parity4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) busy_len = 0;
    else if (enable) begin
      if (busy) begin
        busy_len++;
        chk("busy_expected", 32'(exp_bits.size() > 0), 1);
        if (exp_bits.size() > 0) chk("serial_out", serial_out, exp_bits.pop_front());
      end
      if (done) begin
        chk("done_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_m = exp_q.pop_front();
          chk("q_at_done", q, e_m);
`ifdef SHIFT_ENGINE_PARITY_EN
          chk("parity_at_done", parity, ^e_m);
`endif
        end
        chk("busy_len", busy_len, 14);
        busy_len = 0;
      end
    end
  end

  always @(negedge clk)
    if (resetn && enable && done4) begin
      chk("done4_expected", 32'(exp4.size() > 0), 1);
      if (exp4.size() > 0) begin
        e_4 = exp4.pop_front();
        chk("q4_at_done", q4, e_4);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: final word = load shifted left by sc with the captured bits filling the bottom
  task automatic issue(input logic [13:0] ld, input logic [13:0] sin, input int sc, input bit four);
    int m;
    m = (int'(ld) << sc) | (int'(sin) & ((1 << sc) - 1));
    if (four) exp4.push_back(14'(m));
    else begin
      exp_q.push_back(14'(m));
      for (int k = 1; k <= sc; k++) exp_bits.push_back(ld[14-k]);
    end
    if (four) start4 = 1; else start = 1;
    load_data = ld;
    tick();
  endtask

  task automatic shifts(input logic [13:0] sin, input int sc, input int pause_after);
    logic [13:0] qs;
    for (int k = 1; k <= sc; k++) begin
      serial_in = sin[sc-k];
      tick();
      if (k == pause_after) begin
        qs = q;
        enable = 0;
        repeat (5) tick();
        chk("pause_q", q, qs);
        chk("pause_busy", busy, 1);
        enable = 1;
      end
    end
  endtask

  task automatic run(input logic [13:0] ld, input logic [13:0] sin, input int pause_after);
    issue(ld, sin, 14, 0);
    start = 0;
    shifts(sin, 14, pause_after);
    tick();
  endtask

  initial begin
    logic [13:0] w;
    repeat (3) tick();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q4", q4, 0);
    resetn = 1;
    repeat (10) begin
      tick();
      chk("idle_q", q, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
    run(14'h2A5C, 14'h1337, 0);
`ifdef SHIFT_ENGINE_PARITY_EN
    repeat (3) tick();
    w = 14'h1337;
    chk("parity_hold", parity, ^w);
`endif
    run(14'h0003, 14'h0003, 0);
    issue(14'h3FF0, 14'h000F, 4, 1);
    start4 = 0;
    shifts(14'h000F, 4, 0);
    tick();
    // back-to-back: start stays high; a load_data change while shifting must be ignored
    issue(14'h0001, 14'h0AAA, 14, 0);
    load_data = 14'h1555;
    shifts(14'h0AAA, 14, 0);
    chk("b2b_done", done, 1);
    issue(14'h2000, 14'h3C3C, 14, 0);
    chk("b2b_busy", busy, 1);
    start = 0;
    shifts(14'h3C3C, 14, 0);
    tick();
    run(14'h2A5C, 14'h1337, 6);
    issue(14'h3FFF, 14'h1337, 14, 0);
    start = 0;
    shifts(14'h1337, 3, 0);
    resetn = 0;
    exp_bits.delete();
    exp_q.delete();
    #1;
    chk("abort_q", q, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
`ifdef SHIFT_ENGINE_PARITY_EN
    chk("abort_parity", parity, 0);
`endif
    tick();
    resetn = 1;
    repeat (20) tick();
    chk("abort_idle_q", q, 0);
    repeat (15) begin
      w = 14'($urandom);
      run(w, 14'($urandom), $urandom_range(0, 13));
    end
    repeat (8) begin
      w = 14'($urandom);
      e_4 = 14'($urandom);
      issue(w, e_4, 4, 1);
      start4 = 0;
      shifts(e_4, 4, 0);
      tick();
    end
    repeat (3) tick();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_bits_drained", exp_bits.size(), 0);
    chk("exp4_drained", exp4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
